// File: rtl/varredura_display_bcd_pkg.sv
// Shared types, segment codes ({g,f,e,d,c,b,a}, active-low) and digit count for the display scanner.
// Holds the display definitions used by the scanner and the 7-segment decoder.
package varredura_display_bcd_pkg;

  localparam int NUM_DIGITOS = 7;

  typedef logic [3:0]                   bcd_t;
  typedef logic [6:0]                   seg_t;
  typedef logic [2:0]                   indice_t;
  typedef logic [NUM_DIGITOS-1:0][3:0]  digitos_t;

  localparam seg_t SEG_0       = 7'b1000000;
  localparam seg_t SEG_1       = 7'b1111001;
  localparam seg_t SEG_2       = 7'b0100100;
  localparam seg_t SEG_3       = 7'b0110000;
  localparam seg_t SEG_4       = 7'b0011001;
  localparam seg_t SEG_5       = 7'b0010010;
  localparam seg_t SEG_6       = 7'b0000010;
  localparam seg_t SEG_7       = 7'b1111000;
  localparam seg_t SEG_8       = 7'b0000000;
  localparam seg_t SEG_9       = 7'b0010000;
  localparam seg_t SEG_E       = 7'b0000110;
  localparam seg_t SEG_APAGADO = 7'b1111111;

  localparam indice_t ULTIMO_INDICE = indice_t'(NUM_DIGITOS - 1);

  // Active-high one-hot digit select; bit0 is Unidade.
  function automatic logic [NUM_DIGITOS-1:0] seleciona(input indice_t i);
    return (NUM_DIGITOS)'(1) << i;
  endfunction

endpackage

// File: rtl/varredura_display_bcd_if.sv
// Load port and display outputs of the BCD display scanner.
// Master drives digits and the load strobe; slave (the scanner) drives pronto and the display pins.
interface varredura_display_bcd_if;

  logic       carregar;
  logic [3:0] milhao;
  logic [3:0] centena_milhar;
  logic [3:0] dezena_milhar;
  logic [3:0] milhar;
  logic [3:0] centena;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic       pronto;
  logic [6:0] anodo;
  logic [6:0] segmentos;

  modport master (
    output carregar, milhao, centena_milhar, dezena_milhar, milhar, centena, dezena, unidade,
    input  pronto, anodo, segmentos
  );

  modport slave (
    input  carregar, milhao, centena_milhar, dezena_milhar, milhar, centena, dezena, unidade,
    output pronto, anodo, segmentos
  );

endinterface

// File: rtl/varredura_display_bcd_decodificador_7seg.sv
// Combinational BCD to active-low 7-segment code; any value above 9 shows 'E'.
// Zero latency; no flow control.
module decodificador_7seg
  import varredura_display_bcd_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  always_comb begin
    seg = SEG_E;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/varredura_display_bcd.sv
// 7-digit multiplexed 7-segment scanner; outputs registered, 1 cycle behind the scan index.
// Loads are never refused: newest load wins, applied at the frame boundary (macro SUPRIME_ZEROS_EN: leading-zero blanking).
module varredura_display_bcd
  import varredura_display_bcd_pkg::*;
#(
  parameter int DIV_REFRESH = 50000,
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  varredura_display_bcd_if.slave  bus
);

  localparam int   PW        = $clog2(DIV_REFRESH);
  localparam seg_t DESLIGADO = ATIVO_BAIXO ? 7'b1111111 : 7'b0000000;

  logic [PW-1:0]          presc;
  indice_t                indice;
  digitos_t               pendente;
  digitos_t               exibido;
  digitos_t               entrada;
  logic                   pronto_q;
  logic [6:0]             anodo_q;
  seg_t                   seg_q;

  logic                   wrap;
  logic                   fronteira;
  bcd_t                   digito_sel;
  seg_t                   cod_dec;
  seg_t                   cod;
  logic [NUM_DIGITOS-1:0] apagar;
  logic [NUM_DIGITOS-1:0] onehot;
  logic [6:0]             anodo_n;
  seg_t                   seg_n;

  assign entrada = {bus.milhao, bus.centena_milhar, bus.dezena_milhar, bus.milhar,
                    bus.centena, bus.dezena, bus.unidade};

  assign wrap       = (presc == PW'(DIV_REFRESH - 1));
  assign fronteira  = wrap && (indice == ULTIMO_INDICE);
  assign digito_sel = exibido[indice];

  decodificador_7seg u_dec (
    .bcd (digito_sel),
    .seg (cod_dec)
  );

`ifdef SUPRIME_ZEROS_EN
  // A digit is blanked when it and every more significant digit are zero; Unidade never is.
  always_comb begin
    logic acima_zero;
    apagar     = '0;
    acima_zero = 1'b1;
    for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
      acima_zero = acima_zero && (exibido[i] == 4'd0);
      apagar[i]  = acima_zero;
    end
  end
`else
  assign apagar = '0;
`endif

  always_comb begin
    onehot  = seleciona(indice);
    cod     = apagar[indice] ? SEG_APAGADO : cod_dec;
    anodo_n = ATIVO_BAIXO ? ~onehot : onehot;
    seg_n   = ATIVO_BAIXO ? cod : ~cod;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc    <= '0;
      indice   <= '0;
      pendente <= '0;
      exibido  <= '0;
      pronto_q <= 1'b1;
      anodo_q  <= DESLIGADO;
      seg_q    <= DESLIGADO;
    end else begin
      presc <= wrap ? '0 : presc + PW'(1);
      if (wrap) begin
        indice <= (indice == ULTIMO_INDICE) ? '0 : indice + 3'd1;
      end
      // Pending copies to shown only at the boundary; a same-cycle load refills pending.
      if (fronteira) begin
        exibido <= pendente;
      end
      if (bus.carregar) begin
        pendente <= entrada;
        pronto_q <= 1'b0;
      end else if (fronteira) begin
        pronto_q <= 1'b1;
      end
      anodo_q <= anodo_n;
      seg_q   <= seg_n;
    end
  end

  assign bus.pronto    = pronto_q;
  assign bus.anodo     = anodo_q;
  assign bus.segmentos = seg_q;

endmodule
